irq_arbiter: RTL

Interrupt controller that collects single-cycle interrupt pulses from peripheral blocks (256 Hz timer, prescaled timers, keypad, IR, …) and shares the single CPU interrupt input among them. Sources are synchronised into the system domain, latched as pending flags, masked by bus-programmable enables, and ranked by per-group priority. One vector at a time is presented to the CPU with a request/acknowledge handshake. Sits on the peripheral bus next to the timer blocks, between all `irqs` outputs and the CPU core.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_sync_edge.sv | 44 ++++
 rtl/irq_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and register offsets for the interrupt arbiter.
package irq_pkg;

  // Byte offsets from the register base
  localparam int PRIO_OFF = 0;
  localparam int EN_OFF   = 4;
  localparam int PEND_OFF = 8;

  typedef enum logic {IDLE, PRESENT} irq_state_t;

  typedef logic [1:0] irq_prio_t;

  // Result of one arbitration pass
  typedef struct packed {
    logic      found;
    irq_prio_t level;
    logic [7:0] idx;
  } irq_win_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit 2-flop synchroniser plus rising-edge detector. A rise seen while
// clk_ce is low is held until the next enabled cycle. A level that is already
// high when reset is released is not treated as an edge: a bit only arms once
// a genuine post-reset low has come through the synchroniser.
module irq_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_ce,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] armed;
  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] det;
  logic [1:0]       fill;

  assign det  = s2 & ~s3 & armed;
  assign rise = det | held;

  // Synchroniser, edge history and arming run every clk, independent of clk_ce
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      armed <= '0;
      held  <= '0;
      fill  <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
      // s2 carries a real sample only once two post-reset edges have passed
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2) armed <= armed | ~s2;
      held <= (held | det) & ~{WIDTH{clk_ce}};
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller: synchronised source pulses latch pending flags, which
// are masked by enables, ranked by per-group priority and presented to the
// CPU one vector at a time with a req/ack handshake.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter logic [23:0] REG_BASE    = 24'h2020,
  parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_ce,
  input  logic               bus_write,
  input  logic               bus_read,
  input  logic [23:0]        bus_address_in,
  input  logic [7:0]         bus_data_in,
  output logic [7:0]         bus_data_out,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [1:0]         cpu_level,
  output logic               irq_req,
  output logic [7:0]         irq_vector,
  output logic [1:0]         irq_level,
  input  logic               irq_ack
);

  localparam int NUM_GRP    = NUM_IRQ / 4;
  localparam int PRIO_BYTES = (NUM_GRP + 3) / 4;
  localparam int EN_BYTES   = (NUM_IRQ + 7) / 8;
  localparam int PW         = PRIO_BYTES * 8;
  localparam int EW         = EN_BYTES * 8;
  localparam int IW         = $clog2(NUM_IRQ);

  logic [2*NUM_GRP-1:0] prio_q;
  logic [NUM_IRQ-1:0]   en_q, pend_q;
  logic [NUM_IRQ-1:0]   rise;

  logic [PW-1:0]        prio_pad, prio_wr;
  logic [EW-1:0]        en_pad, en_wr, pend_pad, pend_wclr;
  logic [23:0]          off;
  logic                 wr;

  irq_state_t           state;
  logic [IW-1:0]        cur_idx;
  logic [NUM_IRQ-1:0]   cur_onehot, ack_vec, pend_nxt, en_nxt;
  logic                 ack_fire, cur_live;
  irq_win_t             win;

  logic unused_read;
  assign unused_read = bus_read;

  irq_sync_edge #(.WIDTH(NUM_IRQ)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_ce  (clk_ce),
    .src     (irq_src),
    .rise    (rise)
  );

  // Highest priority wins; a later index only replaces on strictly higher
  // priority, so ties resolve to the lowest index.
  function automatic irq_win_t pick(input logic [NUM_IRQ-1:0]   req,
                                    input logic [2*NUM_GRP-1:0] pr,
                                    input logic [1:0]           lvl);
    irq_win_t  w;
    irq_prio_t p;
    w = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      p = pr[2*(i/4) +: 2];
      if (req[i] && (p > lvl) && (!w.found || (p > w.level))) begin
        w.found = 1'b1;
        w.level = p;
        w.idx   = 8'(i);
      end
    end
    return w;
  endfunction

  // Register decode: read mux and byte-wise write data
  always_comb begin
    off       = bus_address_in - REG_BASE;
    wr        = clk_ce & bus_write;
    prio_pad  = PW'(prio_q);
    en_pad    = EW'(en_q);
    pend_pad  = EW'(pend_q);
    prio_wr   = prio_pad;
    en_wr     = en_pad;
    pend_wclr = '0;
    bus_data_out = '0;
    for (int k = 0; k < PRIO_BYTES; k++) begin
      if (off == 24'(PRIO_OFF + k)) begin
        bus_data_out = prio_pad[8*k +: 8];
        if (wr) prio_wr[8*k +: 8] = bus_data_in;
      end
    end
    for (int k = 0; k < EN_BYTES; k++) begin
      if (off == 24'(EN_OFF + k)) begin
        bus_data_out = en_pad[8*k +: 8];
        if (wr) en_wr[8*k +: 8] = bus_data_in;
      end
      if (off == 24'(PEND_OFF + k)) begin
        bus_data_out = pend_pad[8*k +: 8];
        if (wr) pend_wclr[8*k +: 8] = bus_data_in;
      end
    end
  end

  // Next pending/enable state; a fresh edge beats any clear in the same cycle
  always_comb begin
    ack_fire = clk_ce & irq_ack & (state == PRESENT);
    for (int i = 0; i < NUM_IRQ; i++) cur_onehot[i] = (cur_idx == IW'(i));
    ack_vec  = ack_fire ? cur_onehot : '0;
    pend_nxt = (pend_q & ~pend_wclr[NUM_IRQ-1:0] & ~ack_vec) | rise;
    en_nxt   = en_wr[NUM_IRQ-1:0];
    cur_live = |(pend_nxt & en_nxt & cur_onehot);
    win      = pick(pend_q & en_q, prio_q, cpu_level);
  end

  // Programmable registers and pending flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_q <= '0;
      en_q   <= '0;
      pend_q <= '0;
    end else if (clk_ce) begin
      prio_q <= prio_wr[2*NUM_GRP-1:0];
      en_q   <= en_nxt;
      pend_q <= pend_nxt;
    end
  end

  // Presentation FSM with registered request, vector and level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      irq_level  <= '0;
      cur_idx    <= '0;
    end else if (clk_ce) begin
      case (state)
        IDLE: begin
          if (win.found) begin
            state      <= PRESENT;
            irq_req    <= 1'b1;
            irq_vector <= VECTOR_BASE + win.idx;
            irq_level  <= win.level;
            cur_idx    <= win.idx[IW-1:0];
          end
        end
        PRESENT: begin
          // Ack completes; losing pend/en to a bus write withdraws silently
          if (irq_ack || !cur_live) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
